product_accum: RTL and testbench
================================

# product_accum

Downstream consumer of the M×N multiplier: accepts a stream of signed products and sums a programmed count of them into a guard-extended accumulator. It is the accumulate half of the MAC datapath. The finished sum is held behind a valid/ready output handshake. Runs are started by a one-cycle `start` pulse. Each run ends with exactly one result beat.

## Interface
- `M`, 26: multiplier operand 1 width.
- `N`, 14: multiplier operand 2 width.
- `G`, 4: accumulator guard bits; accumulator width `W = M+N+G`.
- `CNT_W`, 8: width of the run-length field.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  run start pulse; sampled only in IDLE.
- `len`  in  CNT_W  number of products to sum; sampled together with `start`.
- `in_valid`  in  1  `product` is valid.
- `in_ready`  out  1  block accepts `product` this cycle.
- `product`  in  M+N  signed two's-complement multiplier output.
- `out_valid`  out  1  `sum` is valid.
- `out_ready`  in  1  consumer accepts `sum`.
- `sum`  out  W  signed accumulated result.
- `ovf`  out  1  an overflow occurred in this run; valid together with `sum`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has three states: IDLE, ACC and DONE.
- IDLE:
  - `in_ready=0`, `out_valid=0`.
  - `start=1` with `len>=1`: load the counter with `len`, clear the accumulator and `ovf`, go to ACC.
  - `start=1` with `len==0`: clear the accumulator and `ovf`, go directly to DONE. The result is `sum=0`, `ovf=0`.
- ACC:
  - `in_ready=1`.
  - On a handshake (`in_valid && in_ready`): `acc <= acc + sext(product)` and `cnt <= cnt-1`.
  - The handshake that brings `cnt` from 1 to 0 moves the FSM to DONE.
  - If `in_valid=0`, hold state; there is no timeout.
- DONE:
  - `in_ready=0`, `out_valid=1`.
  - `sum` and `ovf` are stable until `out_ready=1`; on that cycle go to IDLE.
- `start` outside IDLE is ignored and is not queued.
- Arithmetic: `product` is sign-extended to W bits. Overflow is signed overflow of the W-bit add: both operands have the same sign and the result sign differs. `ovf` is sticky for the run.
- Reset (`rst_n=0` at a clock edge), including mid-run:
  - FSM returns to IDLE.
  - `acc`, `cnt`, `ovf` are cleared.
  - `in_ready=0`, `out_valid=0`, `sum=0`, `busy=0`.
  - Any partial sum is discarded.

## Timing
- Every output is registered, except `in_ready`, `out_valid` and `busy`, which decode the registered state.
- `start` high at edge t: `busy` and `in_ready` go high in the cycle after t.
- Throughput is one product per cycle in ACC.
- Last product accepted at edge k: `out_valid=1` in the cycle after k, and `sum` already includes that product.
- Latency from the last handshake to result is 1 cycle.
- Minimum run cycle count for len=L with continuous valid and ready: 1 (start) + L + 1 (DONE) edges.
- `out_valid && out_ready` at edge d: IDLE in the cycle after d. A new `start` is sampled no earlier than edge d+1.
- Reset has priority over every other event at the same edge.

## Configuration
- `PRODUCT_ACCUM_SAT_EN` defined:
  - On overflow, the accumulator clamps to `2^(W-1)-1` (positive overflow) or `-2^(W-1)` (negative overflow).
  - Later adds continue from the clamped value.
  - `ovf` is set.
- Undefined:
  - The accumulator wraps modulo `2^W`.
  - `ovf` is still set and sticky.

## Test plan
- Reset mid-run: `len=5`, 3 products accepted, assert `rst_n=0` for 1 cycle. Required after the reset edge: `busy=0`, `in_ready=0`, `out_valid=0`, `sum=0`. A following run with `len=1`, product 7 gives `sum=7`.
- Basic signed sum: `len=3`, products 100, 200, -50 back-to-back, `out_ready=1`.
  - `sum=250`, `ovf=0`.
  - `out_valid` is high exactly 1 cycle, in the cycle after the third handshake.
- Zero length: `start`, `len=0`.
  - `in_ready` never rises.
  - `out_valid=1` the cycle after `start`, with `sum=0`.
- Backpressure and gaps:
  - `len=4`, products 1, 2, 3, 4 with `in_valid` low on alternate cycles.
  - `out_ready` held low for 5 cycles.
  - Required: `sum=10`, stable throughout the stall; `start` pulses during the stall are ignored.
- Overflow: `len=17`, every product `40'h7F_FFFF_FFFF`.
  - Without `PRODUCT_ACCUM_SAT_EN`: `sum=44'h87F_FFFF_FFEF`, `ovf=1`.
  - With `PRODUCT_ACCUM_SAT_EN`: `sum=44'h7FF_FFFF_FFFF`, `ovf=1`.
- Back-to-back runs: `start` in the first IDLE cycle after the DONE handshake. Run 1 is `len=2` (5, 6); run 2 is `len=1` (-3).
  - Results: 11, then -3.
  - `ovf=0` on both.

Source files
------------

// File: rtl/product_accum_if.sv
// Handshake bundle between a product source / result sink and product_accum.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the modports fix who drives each signal.
//   master: drives start, len, in_valid, product, out_ready; observes in_ready, out_valid, sum, ovf, busy
//   slave : the accumulator side of the same signals
interface product_accum_if #(
    parameter int M     = 26,
    parameter int N     = 14,
    parameter int G     = 4,
    parameter int CNT_W = 8
);
    localparam int W = M + N + G;

    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [M+N-1:0]   product;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     sum;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, product, out_ready,
        input  in_ready, out_valid, sum, ovf, busy
    );

    modport slave (
        input  start, len, in_valid, product, out_ready,
        output in_ready, out_valid, sum, ovf, busy
    );
endinterface

// File: rtl/product_accum.sv
// Sums a programmed number of signed multiplier products into a guard-extended accumulator.
// Latency: result valid one cycle after the last product handshake; one product per cycle while accumulating.
// Backpressure: in_ready only while accumulating; the result is held in DONE until out_ready.
//   Ports: clk, rst_n (synchronous, active-low); bus (product_accum_if.slave) carries start/len,
//   the product valid/ready stream, the sum/ovf valid/ready result, and busy.
//   Build option: define PRODUCT_ACCUM_SAT_EN to clamp on overflow instead of wrapping.
module product_accum #(
    parameter int M     = 26,
    parameter int N     = 14,
    parameter int G     = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    product_accum_if.slave        bus
);
    localparam int W = M + N + G;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;

    logic [W-1:0]     prod_ext;
    logic [W-1:0]     add_raw;
    logic             add_ovf;
    logic [W-1:0]     acc_nxt;

    // Signed overflow: operands agree in sign, result does not.
    assign prod_ext = {{G{bus.product[M+N-1]}}, bus.product};
    assign add_raw  = acc + prod_ext;
    assign add_ovf  = (acc[W-1] == prod_ext[W-1]) && (add_raw[W-1] != acc[W-1]);

`ifdef PRODUCT_ACCUM_SAT_EN
    // The sign of the overflowing operands tells which rail to clamp to.
    always_comb begin
        acc_nxt = add_raw;
        if (add_ovf) begin
            acc_nxt = acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign acc_nxt = add_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        ovf_q <= 1'b0;
                        cnt   <= bus.len;
                        // A zero-length run produces an empty (zero) result immediately.
                        state <= (bus.len == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc   <= acc_nxt;
                        ovf_q <= ovf_q | add_ovf;
                        cnt   <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = acc;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_product_accum.sv
module tb_product_accum;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    product_accum_if #(.M(26), .N(14), .G(4), .CNT_W(8)) bus ();

    product_accum #(.M(26), .N(14), .G(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]       len;
        logic [3:0][39:0] p;
        logic [43:0]      sum;
        logic             ovf;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // All driving and sampling happen on the falling edge.
    task automatic start_run(input logic [7:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [39:0] p);
        bus.in_valid = 1'b1;
        bus.product  = p;
        chk("in_ready_during_acc", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [43:0] s, input logic o);
        chk({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_sum"}, 64'(bus.sum), 64'(s));
        chk({name, "_ovf"}, 64'(bus.ovf), 64'(o));
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.product   = '0;
        bus.out_ready = 1'b1;

        tbl[0].len = 8'd3; tbl[0].p[0] = 40'd100; tbl[0].p[1] = 40'd200; tbl[0].p[2] = -40'sd50; tbl[0].p[3] = '0;
        tbl[0].sum = 44'd250; tbl[0].ovf = 1'b0;
        tbl[1].len = 8'd1; tbl[1].p[0] = 40'd7; tbl[1].p[1] = '0; tbl[1].p[2] = '0; tbl[1].p[3] = '0;
        tbl[1].sum = 44'd7; tbl[1].ovf = 1'b0;
        tbl[2].len = 8'd4; tbl[2].p[0] = -40'sd1; tbl[2].p[1] = -40'sd2; tbl[2].p[2] = -40'sd3; tbl[2].p[3] = -40'sd4;
        tbl[2].sum = -44'sd10; tbl[2].ovf = 1'b0;
        tbl[3].len = 8'd2; tbl[3].p[0] = 40'h80_0000_0000; tbl[3].p[1] = 40'h80_0000_0000; tbl[3].p[2] = '0; tbl[3].p[3] = '0;
        tbl[3].sum = 44'hF00_0000_0000; tbl[3].ovf = 1'b0;
        tbl[4].len = 8'd4; tbl[4].p[0] = 40'd1; tbl[4].p[1] = 40'd2; tbl[4].p[2] = 40'd3; tbl[4].p[3] = 40'd4;
        tbl[4].sum = 44'd10; tbl[4].ovf = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs with continuous valid and ready.
        for (int v = 0; v < 5; v++) begin
            start_run(tbl[v].len);
            chk("tbl_busy_after_start", 64'(bus.busy), 64'd1);
            for (int i = 0; i < int'(tbl[v].len); i++) feed(tbl[v].p[i]);
            check_result($sformatf("tbl%0d", v), tbl[v].sum, tbl[v].ovf);
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid_one_cycle", v), 64'(bus.out_valid), 64'd0);
            chk($sformatf("tbl%0d_idle", v), 64'(bus.busy), 64'd0);
        end

        // Reset mid-run discards the partial sum.
        start_run(8'd5);
        feed(40'd11);
        feed(40'd22);
        feed(40'd33);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_sum", 64'(bus.sum), 64'd0);
        @(negedge clk);
        start_run(8'd1);
        feed(40'd7);
        check_result("after_rst", 44'd7, 1'b0);
        @(negedge clk);

        // Zero length goes straight to DONE with an empty sum.
        start_run(8'd0);
        chk("zero_in_ready", 64'(bus.in_ready), 64'd0);
        check_result("zero", 44'd0, 1'b0);
        @(negedge clk);
        chk("zero_idle", 64'(bus.busy), 64'd0);

        // Input gaps and output stall with ignored start pulses.
        bus.out_ready = 1'b0;
        start_run(8'd4);
        for (int i = 1; i <= 4; i++) begin
            feed(40'(i));
            if (i < 4) begin
                chk("gap_out_valid", 64'(bus.out_valid), 64'd0);
                @(negedge clk);
            end
        end
        for (int c = 0; c < 5; c++) begin
            check_result($sformatf("stall%0d", c), 44'd10, 1'b0);
            bus.start = (c % 2 == 0);
            bus.len   = 8'd3;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_result("stall_end", 44'd10, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_released", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("start_not_queued", 64'(bus.busy), 64'd0);

        // Overflow: 17 maximal positive products.
        start_run(8'd17);
        for (int i = 0; i < 17; i++) feed(40'h7F_FFFF_FFFF);
`ifdef PRODUCT_ACCUM_SAT_EN
        check_result("ovf", 44'h7FF_FFFF_FFFF, 1'b1);
`else
        check_result("ovf", 44'h87F_FFFF_FFEF, 1'b1);
`endif
        @(negedge clk);

        // Back-to-back runs: new start in the first IDLE cycle.
        start_run(8'd2);
        feed(40'd5);
        feed(40'd6);
        check_result("b2b_run1", 44'd11, 1'b0);
        @(negedge clk);
        chk("b2b_idle", 64'(bus.busy), 64'd0);
        start_run(8'd1);
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        feed(-40'sd3);
        check_result("b2b_run2", -44'sd3, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
